// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the ProtoCore 8-bit datapath.
// Drives every datapath control and runs the instruction and data RAM req/ack handshakes.
`timescale 1ns/1ps

module control_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pause_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [7:0]          dmem_addr,
  output logic [7:0]          dmem_wdata,
  input  logic                dmem_ack,
  output logic                write_alu,
  output logic                write_en,
  output logic                is_load,
  output logic                imm_flag,
  output logic                cpu_paused,
  output logic [2:0]          alu_opcode,
  output logic [3:0]          write_addr,
  output logic [3:0]          ra_addr,
  output logic [3:0]          rb_addr,
  output logic [7:0]          imm_data,
  input  logic [7:0]          read_a,
  input  logic [7:0]          read_b,
  input  logic                alu_zero,
  input  logic                alu_carry,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_PAUSED, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [3:0]          op;

  assign op         = ir_q[15:12];
  assign ra_addr    = ir_q[7:4];
  assign rb_addr    = ir_q[3:0];
  assign write_addr = ir_q[11:8];
  assign imm_data   = ir_q[7:0];
  assign alu_opcode = ir_q[14:12];
  assign imem_addr  = pc_q;
  assign pc         = pc_q;

  // Data bus is only driven while a transfer is in flight.
  assign dmem_addr  = (state_q == S_MEM) ? read_a : 8'h00;
  assign dmem_wdata = (state_q == S_MEM) ? read_b : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make update order depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'hE000;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that skipped an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    z_d        = z_q;
    c_d        = c_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    write_en   = 1'b0;
    write_alu  = 1'b0;
    is_load    = 1'b0;
    imm_flag   = 1'b0;
    cpu_paused = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (pause_req) begin
          state_d = S_PAUSED;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_data;
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_DECODE;
          end
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_LDI: begin
            write_en = 1'b1;
            imm_flag = 1'b1;
          end
          OP_LD, OP_ST: state_d = S_MEM;
          OP_JMP:       pc_d    = PC_WIDTH'(ir_q[7:0]);
          OP_JZ:        if (z_q) pc_d = PC_WIDTH'(ir_q[7:0]);
          OP_JC:        if (c_q) pc_d = PC_WIDTH'(ir_q[7:0]);
          OP_NOP:       ;
          OP_HALT:      state_d = S_HALT;
          default: begin
            // Opcodes 0x0-0x7: register-register ALU operation.
            write_en  = 1'b1;
            write_alu = 1'b1;
            z_d       = alu_zero;
            c_d       = alu_carry;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (op == OP_LD) begin
          write_en = dmem_ack;
          is_load  = dmem_ack;
        end
        if (dmem_ack) state_d = S_FETCH;
      end

      S_PAUSED: begin
        cpu_paused = 1'b1;
        if (!pause_req) state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a small ROM/RAM/register-file/ALU environment
// answers the handshakes, expected fetch/write/memory events are queued per program.
`timescale 1ns/1ps

module tb_control_unit;

  logic        clk, rst, pause_req;
  logic [7:0]  imem_addr, pc;
  logic        imem_req, imem_ack;
  logic [15:0] imem_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic        write_alu, write_en, is_load, imm_flag, cpu_paused, halted;
  logic [2:0]  alu_opcode;
  logic [3:0]  write_addr, ra_addr, rb_addr;
  logic [7:0]  imm_data, read_a, read_b;
  logic        alu_zero, alu_carry;

  control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .write_alu(write_alu), .write_en(write_en), .is_load(is_load), .imm_flag(imm_flag),
    .cpu_paused(cpu_paused), .alu_opcode(alu_opcode), .write_addr(write_addr),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .imm_data(imm_data),
    .read_a(read_a), .read_b(read_b), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment: ROM, RAM, register file, ALU ----------------
  logic [15:0] rom [256];
  logic [7:0]  ram [256];
  logic [7:0]  regs [16];
  logic [7:0]  ram_data, alu_res, wr_data;
  logic        alu_c;
  int          dmem_delay;
  int          dwait;

  assign imem_ack  = imem_req;
  assign imem_data = rom[imem_addr];
  assign read_a    = regs[ra_addr];
  assign read_b    = regs[rb_addr];
  assign ram_data  = ram[dmem_addr];
  assign dmem_ack  = dmem_req && (dwait >= dmem_delay);

  always_comb begin
    alu_c   = 1'b0;
    alu_res = read_a;
    case (alu_opcode)
      3'd0:    {alu_c, alu_res} = {1'b0, read_a} + {1'b0, read_b};
      3'd1:    {alu_c, alu_res} = {1'b0, read_a} - {1'b0, read_b};
      3'd2:    alu_res = read_a & read_b;
      3'd3:    alu_res = read_a | read_b;
      default: alu_res = read_a ^ read_b;
    endcase
  end
  assign alu_zero  = (alu_res == 8'h00);
  assign alu_carry = alu_c;
  assign wr_data   = is_load ? ram_data : (imm_flag ? imm_data : alu_res);

  always @(posedge clk) begin
    if (!rst && write_en && write_addr != 4'h0) regs[write_addr] <= wr_data;
    if (dmem_req && dmem_ack && dmem_we) ram[dmem_addr] <= dmem_wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                       dwait <= 0;
    else if (dmem_req && !dmem_ack) dwait <= dwait + 1;
    else                           dwait <= 0;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // kind: 0 fetch, 1 register write (aux = source 0 alu/1 imm/2 load), 2 data transfer (aux = we)
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         aux;
    int         len;
  } ev_t;

  ev_t sb[$];

  function automatic void push(int kind, logic [7:0] a, logic [7:0] d, int aux, int len);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.aux = aux; e.len = len;
    sb.push_back(e);
  endfunction
  function automatic void ef(logic [7:0] a);                  push(0, a, 8'h00, 0, 0);  endfunction
  function automatic void ew(logic [7:0] a, logic [7:0] d, int src); push(1, a, d, src, 0); endfunction
  function automatic void em(int we, logic [7:0] a, logic [7:0] d, int len); push(2, a, d, we, len); endfunction

  task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d,
                         input int aux, input int len);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_unexpected: got event kind %0d addr 0x%0h, expected none", kind, a);
    end else begin
      e = sb.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_addr", {24'h0, a}, {24'h0, e.addr});
      if (e.kind != 0) begin
        check("sb_data", {24'h0, d}, {24'h0, e.data});
        check("sb_aux", aux, e.aux);
      end
      if (e.kind == 2) check("sb_len", len, e.len);
    end
  endtask

  int edges, nwrites, third_wr;

  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      nwrites  = 0;
      third_wr = 0;
    end else begin
      if (imem_req && imem_ack) observe(0, imem_addr, 8'h00, 0, 0);
      if (dmem_req && dmem_ack)
        observe(2, dmem_addr, dmem_we ? dmem_wdata : ram_data, int'(dmem_we), dwait + 1);
      if (write_en) begin
        observe(1, {4'h0, write_addr}, wr_data,
                is_load ? 2 : (imm_flag ? 1 : (write_alu ? 0 : 3)), 0);
        nwrites++;
        if (nwrites == 3) third_wr = edges + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check({tag, "_halted"}, halted, 1);
    repeat (4) @(negedge clk);
    check({tag, "_no_req_after_halt"}, {imem_req, dmem_req}, 2'b00);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    rst        = 1'b1;
    pause_req  = 1'b0;
    dmem_delay = 0;
    clear_rom();
    #1;
    check("rst_imem_req", imem_req, 1);
    check("rst_imem_addr", imem_addr, 8'h00);
    check("rst_idle_ctrl", {dmem_req, dmem_we, write_en, write_alu, is_load, imm_flag,
                            cpu_paused, halted}, 8'h00);
    check("rst_fields", {write_addr, ra_addr, rb_addr, imm_data}, 20'h0);

    // T1: LDI r1,7F; LDI r2,0A; SUB r3,r1,r2
    rom[0] = 16'h817F; rom[1] = 16'h820A; rom[2] = 16'h1312;
    ef(8'h00); ew(8'h1, 8'h7F, 1); ef(8'h01); ew(8'h2, 8'h0A, 1);
    ef(8'h02); ew(8'h3, 8'h75, 0); ef(8'h03);
    do_reset();
    wait_halted("t1");
    check("t1_write_count", nwrites, 3);
    check("t1_third_write_cycle", third_wr, 9);
    check("t1_r3", regs[3], 8'h75);

    // T2: FF+01 -> C=1,Z=1; JC 20 taken, then JZ 30 taken
    clear_rom();
    rom[0] = 16'h81FF; rom[1] = 16'h8201; rom[2] = 16'h0312; rom[3] = 16'hD020;
    rom[8'h20] = 16'hC030;
    ef(8'h00); ew(8'h1, 8'hFF, 1); ef(8'h01); ew(8'h2, 8'h01, 1);
    ef(8'h02); ew(8'h3, 8'h00, 0); ef(8'h03); ef(8'h20); ef(8'h30);
    do_reset();
    wait_halted("t2");

    // T3: 01+01 -> no carry, not zero; both branches fall through
    clear_rom();
    rom[0] = 16'h8101; rom[1] = 16'h8201; rom[2] = 16'h0312; rom[3] = 16'hD020;
    rom[4] = 16'hC030;
    ef(8'h00); ew(8'h1, 8'h01, 1); ef(8'h01); ew(8'h2, 8'h01, 1);
    ef(8'h02); ew(8'h3, 8'h02, 0); ef(8'h03); ef(8'h04); ef(8'h05);
    do_reset();
    wait_halted("t3");

    // T4: ST [r4],r5 then LD r6,[r4] with 3-cycle RAM wait
    clear_rom();
    rom[0] = 16'h8410; rom[1] = 16'h85AB; rom[2] = 16'hA045; rom[3] = 16'h9640;
    dmem_delay = 3;
    ef(8'h00); ew(8'h4, 8'h10, 1); ef(8'h01); ew(8'h5, 8'hAB, 1);
    ef(8'h02); em(1, 8'h10, 8'hAB, 4); ef(8'h03); em(0, 8'h10, 8'hAB, 4);
    ew(8'h6, 8'hAB, 2); ef(8'h04);
    do_reset();
    wait_halted("t4");
    check("t4_r6", regs[6], 8'hAB);
    dmem_delay = 0;

    // T5: pause raised during EXEC of LDI, released later
    clear_rom();
    rom[0] = 16'h8155;
    ef(8'h00); ew(8'h1, 8'h55, 1); ef(8'h01);
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (write_en) break;
    end
    check("t5_saw_exec", write_en, 1);
    pause_req = 1'b1;
    @(negedge clk);
    check("t5_fetch_no_req", {imem_req, cpu_paused}, 2'b00);
    @(negedge clk);
    check("t5_paused", {cpu_paused, imem_req, dmem_req}, 3'b100);
    check("t5_paused_pc", pc, 8'h01);
    repeat (3) @(negedge clk);
    check("t5_still_paused", {cpu_paused, imem_req}, 2'b10);
    pause_req = 1'b0;
    @(negedge clk);
    check("t5_resumed", {cpu_paused, imem_req}, 2'b01);
    wait_halted("t5");

    // T6: JMP FF; NOP at FF wraps pc to 00; JC now taken to 05
    clear_rom();
    rom[0] = 16'hD005; rom[1] = 16'h81FF; rom[2] = 16'h8201; rom[3] = 16'h0312;
    rom[4] = 16'hB0FF; rom[8'hFF] = 16'hE000;
    ef(8'h00); ef(8'h01); ew(8'h1, 8'hFF, 1); ef(8'h02); ew(8'h2, 8'h01, 1);
    ef(8'h03); ew(8'h3, 8'h00, 0); ef(8'h04); ef(8'hFF); ef(8'h00); ef(8'h05);
    do_reset();
    wait_halted("t6");

    // T7: reset asserted mid-MEM of LD aborts the register write
    clear_rom();
    rom[0] = 16'h865A; rom[1] = 16'h9610;
    dmem_delay = 1000;
    ef(8'h00); ew(8'h6, 8'h5A, 1); ef(8'h01);
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_req) break;
    end
    check("t7_in_mem", {dmem_req, dmem_we}, 2'b10);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_drops_req", {dmem_req, write_en, is_load}, 3'b000);
    check("t7_rst_pc", pc, 8'h00);
    check("t7_rst_fetch", {imem_req, imem_addr}, 9'h100);
    rom[0] = 16'hF000;
    dmem_delay = 0;
    check("t7_sb_drained", sb.size(), 0);
    ef(8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_halted("t7");
    check("t7_r6_kept", regs[6], 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
